menu_key_controller: RTL and testbench

Upstream input stage for the seven-segment output multiplexer. It turns the four raw active-low board pushbuttons into a registered 8-bit page `Selector` and a one-cycle `Increment` strobe, which the multiplexer, the person counter and the area counter consume directly. Each key passes through a 2-flop synchroniser and a debounce counter. The Increment key auto-repeats while held, and a page FSM maps key presses to the page codes the display understands.

---
 rtl/menu_key_controller_pkg.sv | 51 +++++
 rtl/menu_key_controller_key_debounce.sv | 62 ++++++
 rtl/menu_key_controller.sv | 150 +++++++++++++++
 tb/tb_menu_key_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_key_controller_pkg.sv
// Shared page codes, FSM encoding and key-event helpers for the menu key
// controller and the display-side consumers of Selector.
package menu_key_controller_pkg;

    // Page codes understood by the seven-segment multiplexer and counters.
    localparam logic [7:0] PAGE_CLOCK       = 8'd0;
    localparam logic [7:0] PAGE_PERSON      = 8'd4;
    localparam logic [7:0] PAGE_AREA        = 8'd5;
    localparam logic [7:0] PAGE_LAST        = 8'd7;
    localparam logic [7:0] PAGE_EDIT_PERSON = 8'd20;
    localparam logic [7:0] PAGE_EDIT_AREA   = 8'd21;

    // Two-state page FSM: browsing pages 0..7 or editing page 20/21.
    typedef enum logic {
        ST_BROWSE = 1'b0,
        ST_EDIT   = 1'b1
    } page_state_e;

    // The single key event that acts in a cycle after priority resolution.
    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_ENTER = 3'd1,
        EV_NEXT  = 3'd2,
        EV_PREV  = 3'd3,
        EV_INC   = 3'd4
    } key_event_e;

    // Enter > Next > Prev > Inc; lower-priority strobes are simply dropped.
    function automatic key_event_e pick_event(input logic enter_p,
                                              input logic next_p,
                                              input logic prev_p,
                                              input logic inc_p);
        key_event_e ev;
        ev = EV_NONE;
        if (enter_p)     ev = EV_ENTER;
        else if (next_p) ev = EV_NEXT;
        else if (prev_p) ev = EV_PREV;
        else if (inc_p)  ev = EV_INC;
        return ev;
    endfunction

    // Step a browse page forward or backward with wrap-around over 0..7.
    function automatic logic [7:0] page_step(input logic [7:0] page,
                                             input logic       forward);
        logic [7:0] res;
        if (forward) res = (page == PAGE_LAST)  ? PAGE_CLOCK : page + 8'd1;
        else         res = (page == PAGE_CLOCK) ? PAGE_LAST  : page - 8'd1;
        return res;
    endfunction

endpackage

// File: rtl/menu_key_controller_key_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle press strobe on each released->pressed transition.
module key_debounce
    import menu_key_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,   // raw, active-low, asynchronous to clk
    output logic level,   // debounced level, 1 = pressed
    output logic press    // one cycle high when level flips to pressed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          pressed_now;

    // Synchronise, count consecutive mismatches, flip level when stable long enough.
    // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        pressed_now = ~sync2_q;
        level_d     = level_q;
        cnt_d       = '0;
        press       = 1'b0;
        if (pressed_now != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = pressed_now;
                press   = pressed_now;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers; synchroniser resets to the released (high) raw level.
    // NOTE: sequential state uses non-blocking assignments so all flops sample the pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: resetting the synchroniser to "released" forces a held key to debounce again after reset.
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/menu_key_controller.sv
// Menu key front end: debounces four pushbuttons, runs the browse/edit page
// FSM producing Selector, and generates Increment with auto-repeat in EDIT.
module menu_key_controller
    import menu_key_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       KeyNext_n,
    input  logic       KeyPrev_n,
    input  logic       KeyEnter_n,
    input  logic       KeyInc_n,
    output logic [7:0] Selector,
    output logic       Increment,
    output logic       Editing
);

    localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] HOLD_T   = RW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REPEAT_T = RW'(REPEAT_CYCLES);

    logic enter_level, next_level, prev_level, inc_level;
    logic enter_press, next_press, prev_press, inc_press;
    logic unused_levels;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
        .clk(Clock), .rst_n(Reset_n), .key_n(KeyEnter_n),
        .level(enter_level), .press(enter_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk(Clock), .rst_n(Reset_n), .key_n(KeyNext_n),
        .level(next_level), .press(next_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
        .clk(Clock), .rst_n(Reset_n), .key_n(KeyPrev_n),
        .level(prev_level), .press(prev_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
        .clk(Clock), .rst_n(Reset_n), .key_n(KeyInc_n),
        .level(inc_level), .press(inc_press)
    );

    // Enter/Next/Prev act only on their press strobe; their held level is not needed.
    assign unused_levels = enter_level ^ next_level ^ prev_level;

    page_state_e   state_q, state_d;
    logic [7:0]    selector_q, selector_d;
    logic          increment_q, increment_d;
    logic          editing_q, editing_d;
    logic          rep_active_q, rep_active_d;   // auto-repeat armed by an Inc press in EDIT
    logic          repeating_q, repeating_d;     // past the initial hold delay
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;         // cycles since the last Increment event
    logic [RW-1:0] rep_target;
    logic          inc_accept;
    key_event_e    key_event;

    assign key_event  = pick_event(enter_press, next_press, prev_press, inc_press);
    assign rep_target = repeating_q ? REPEAT_T : HOLD_T;

    // Page FSM next-state, Increment generation and auto-repeat timing.
    always_comb begin
        state_d      = state_q;
        selector_d   = selector_q;
        increment_d  = 1'b0;
        rep_active_d = rep_active_q;
        repeating_d  = repeating_q;
        rep_cnt_d    = rep_cnt_q;
        inc_accept   = 1'b0;

        unique case (state_q)
            ST_BROWSE: begin
                case (key_event)
                    EV_ENTER: begin
                        if (selector_q == PAGE_PERSON) begin
                            selector_d = PAGE_EDIT_PERSON;
                            state_d    = ST_EDIT;
                        end else if (selector_q == PAGE_AREA) begin
                            selector_d = PAGE_EDIT_AREA;
                            state_d    = ST_EDIT;
                        end
                    end
                    EV_NEXT: selector_d = page_step(selector_q, 1'b1);
                    EV_PREV: selector_d = page_step(selector_q, 1'b0);
                    default: ;
                endcase
            end
            ST_EDIT: begin
                case (key_event)
                    EV_ENTER: begin
                        selector_d = (selector_q == PAGE_EDIT_AREA) ? PAGE_AREA : PAGE_PERSON;
                        state_d    = ST_BROWSE;
                    end
                    EV_INC:  inc_accept = 1'b1;
                    default: ;
                endcase
            end
        endcase

        if (inc_accept) begin
            increment_d  = 1'b1;
            rep_active_d = 1'b1;
            repeating_d  = 1'b0;
            rep_cnt_d    = RW'(1);
        end else if (rep_active_q) begin
            if (!inc_level || (selector_d != selector_q) || (state_d != ST_EDIT)) begin
                rep_active_d = 1'b0;
                repeating_d  = 1'b0;
                rep_cnt_d    = '0;
            end else if (rep_cnt_q == rep_target) begin
                increment_d = 1'b1;
                repeating_d = 1'b1;
                rep_cnt_d   = RW'(1);
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end

        editing_d = (state_d == ST_EDIT);
    end

    // Output and control registers; all outputs come straight from these flops.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_BROWSE;
            selector_q   <= PAGE_CLOCK;
            increment_q  <= 1'b0;
            editing_q    <= 1'b0;
            rep_active_q <= 1'b0;
            repeating_q  <= 1'b0;
            rep_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            selector_q   <= selector_d;
            increment_q  <= increment_d;
            editing_q    <= editing_d;
            rep_active_q <= rep_active_d;
            repeating_q  <= repeating_d;
            rep_cnt_q    <= rep_cnt_d;
        end
    end

    assign Selector  = selector_q;
    assign Increment = increment_q;
    assign Editing   = editing_q;

endmodule

// File: tb/tb_menu_key_controller.sv
// Self-checking bench for menu_key_controller with short debounce/repeat timing.
module tb_menu_key_controller;

    localparam int DB = 4;
    localparam int HC = 20;
    localparam int RC = 8;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       KeyNext_n = 1'b1;
    logic       KeyPrev_n = 1'b1;
    logic       KeyEnter_n = 1'b1;
    logic       KeyInc_n = 1'b1;
    logic [7:0] Selector;
    logic       Increment;
    logic       Editing;

    menu_key_controller #(
        .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .KeyNext_n(KeyNext_n), .KeyPrev_n(KeyPrev_n),
        .KeyEnter_n(KeyEnter_n), .KeyInc_n(KeyInc_n),
        .Selector(Selector), .Increment(Increment), .Editing(Editing)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raw-sample history per key (index 0 enter, 1 next, 2 prev, 3 inc).
    bit hist [4][DB+1];
    bit lvl [4];
    int m_sel;
    bit m_inc;
    bit act;
    int t0;
    int ecount;

    int pulses;
    int edge_no;
    int pulse_edges[$];

    typedef struct {
        bit [3:0] keys;     // {enter, next, prev, inc}, 1 = pressed
        int       exp_sel;
        bit       exp_edit;
        int       exp_pulses;
    } vec_t;

    vec_t tbl [26];

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i <= DB; i++) hist[k][i] = 1'b1;
            lvl[k] = 1'b0;
        end
        m_sel = 0;
        m_inc = 1'b0;
        act   = 1'b0;
        t0    = 0;
    endtask

    // A key is accepted as pressed (released) when the last DB samples seen
    // past the two synchroniser stages all disagree with its current level.
    task automatic model_edge();
        bit raw [4];
        bit st [4];
        bit nl [4];
        bit all_p, all_r, old_inc, edit;
        int old_sel, el;
        ecount++;
        raw[0] = KeyEnter_n; raw[1] = KeyNext_n; raw[2] = KeyPrev_n; raw[3] = KeyInc_n;
        for (int k = 0; k < 4; k++) begin
            all_p = 1'b1;
            all_r = 1'b1;
            for (int i = 1; i <= DB; i++) begin
                if (hist[k][i]) all_p = 1'b0;
                else            all_r = 1'b0;
            end
            st[k] = !lvl[k] && all_p;
            nl[k] = lvl[k] ? !all_r : all_p;
            for (int i = DB; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = raw[k];
        end
        old_inc = lvl[3];
        old_sel = m_sel;
        edit    = (m_sel >= 20);
        m_inc   = 1'b0;
        if (st[0]) begin
            case (m_sel)
                4:  m_sel = 20;
                5:  m_sel = 21;
                20: m_sel = 4;
                21: m_sel = 5;
                default: ;
            endcase
        end else if (st[1]) begin
            if (!edit) m_sel = (m_sel + 1) % 8;
        end else if (st[2]) begin
            if (!edit) m_sel = (m_sel + 7) % 8;
        end
        if (!st[0] && !st[1] && !st[2] && st[3] && edit) begin
            m_inc = 1'b1;
            act   = 1'b1;
            t0    = ecount;
        end else if (act) begin
            if (!old_inc || m_sel != old_sel || m_sel < 20) begin
                act = 1'b0;
            end else begin
                el = ecount - t0;
                if (el == HC || (el > HC && (el - HC) % RC == 0)) m_inc = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) lvl[k] = nl[k];
    endtask

    // One clock: advance the model, clock the DUT, compare at the falling edge.
    task automatic step();
        logic [7:0] es;
        logic       ee;
        if (!Reset_n) model_reset();
        else          model_edge();
        @(posedge Clock);
        @(negedge Clock);
        edge_no++;
        es = 8'(m_sel);
        ee = (m_sel >= 20);
        n_cmp++;
        if (Selector !== es || Increment !== m_inc || Editing !== ee) begin
            n_bad++;
            $display("FAIL cycle %0d: got sel=%0d inc=%b edit=%b, expected sel=%0d inc=%b edit=%b",
                     edge_no, Selector, Increment, Editing, es, m_inc, ee);
        end
        if (Increment === 1'b1) begin
            pulses++;
            pulse_edges.push_back(edge_no);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_keys(input bit [3:0] m);
        KeyEnter_n = !m[3];
        KeyNext_n  = !m[2];
        KeyPrev_n  = !m[1];
        KeyInc_n   = !m[0];
    endtask

    task automatic tap(input bit [3:0] m);
        set_keys(m);
        run(DB + 5);
        set_keys(4'h0);
        run(DB + 5);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rep [5];
        int base;
        bit [3:0] m;

        tbl = '{
            '{4'h4, 1, 1'b0, 0}, '{4'h4, 2, 1'b0, 0}, '{4'h4, 3, 1'b0, 0},
            '{4'h4, 4, 1'b0, 0}, '{4'h4, 5, 1'b0, 0}, '{4'h4, 6, 1'b0, 0},
            '{4'h4, 7, 1'b0, 0}, '{4'h4, 0, 1'b0, 0}, '{4'h2, 7, 1'b0, 0},
            '{4'h4, 0, 1'b0, 0}, '{4'h4, 1, 1'b0, 0}, '{4'h4, 2, 1'b0, 0},
            '{4'h4, 3, 1'b0, 0}, '{4'h8, 3, 1'b0, 0}, '{4'h1, 3, 1'b0, 0},
            '{4'h4, 4, 1'b0, 0}, '{4'h8, 20, 1'b1, 0}, '{4'h4, 20, 1'b1, 0},
            '{4'h2, 20, 1'b1, 0}, '{4'h1, 20, 1'b1, 1}, '{4'h8, 4, 1'b0, 0},
            '{4'h4, 5, 1'b0, 0}, '{4'h8, 21, 1'b1, 0}, '{4'h1, 21, 1'b1, 1},
            '{4'h8, 5, 1'b0, 0}, '{4'h2, 4, 1'b0, 0}
        };
        exp_rep = '{6, 26, 34, 42, 50};
        edge_no = 0;
        ecount  = 0;
        model_reset();

        // Reset state.
        @(negedge Clock);
        run(3);
        check("reset selector", Selector, 0);
        check("reset increment", Increment, 0);
        check("reset editing", Editing, 0);
        Reset_n = 1'b1;
        run(2);

        // Table: single key taps with expected page, edit flag and Increment count.
        for (int i = 0; i < 26; i++) begin
            pulses = 0;
            tap(tbl[i].keys);
            check($sformatf("vec%0d selector", i), Selector, tbl[i].exp_sel);
            check($sformatf("vec%0d editing", i), Editing, tbl[i].exp_edit);
            check($sformatf("vec%0d pulses", i), pulses, tbl[i].exp_pulses);
        end

        // Bounce: 2-cycle toggles never reach the debounce count, then a steady hold.
        for (int i = 0; i < 10; i++) begin
            KeyNext_n = (i % 2 != 0);
            run(2);
        end
        KeyNext_n = 1'b0;
        run(5);
        check("bounce before step", Selector, 4);
        run(1);
        check("bounce step at 6", Selector, 5);
        run(10);
        check("bounce single step", Selector, 5);
        KeyNext_n = 1'b1;
        run(12);

        // Auto-repeat in page 21.
        tap(4'h8);
        check("enter edit area", Selector, 21);
        pulse_edges.delete();
        base = edge_no;
        KeyInc_n = 1'b0;
        run(55);
        check("repeat pulse count", pulse_edges.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < pulse_edges.size())
                check($sformatf("repeat pulse %0d offset", i), pulse_edges[i] - base, exp_rep[i]);
        end
        KeyInc_n = 1'b1;
        run(15);

        // Same hold in BROWSE gives nothing.
        tap(4'h8);
        check("exit to area", Selector, 5);
        pulses = 0;
        KeyInc_n = 1'b0;
        run(60);
        check("browse hold pulses", pulses, 0);
        KeyInc_n = 1'b1;
        run(12);

        // Simultaneous Enter + Inc at page 20.
        tap(4'h2);
        tap(4'h8);
        check("at edit person", Selector, 20);
        pulses = 0;
        tap(4'h9);
        check("enter+inc selector", Selector, 4);
        check("enter+inc pulses", pulses, 0);
        check("enter+inc editing", Editing, 0);

        // Simultaneous Next + Prev at page 2.
        tap(4'h2);
        tap(4'h2);
        check("at page 2", Selector, 2);
        tap(4'h6);
        check("next+prev selector", Selector, 3);

        // Reset while Next is held.
        KeyNext_n = 1'b0;
        run(10);
        Reset_n = 1'b0;
        run(3);
        check("mid-hold reset selector", Selector, 0);
        Reset_n = 1'b1;
        run(5);
        check("post-reset before step", Selector, 0);
        run(1);
        check("post-reset step at 6", Selector, 1);
        run(10);
        check("post-reset single step", Selector, 1);
        KeyNext_n = 1'b1;
        run(12);

        // Randomised key activity against the model.
        for (int s = 0; s < 150; s++) begin
            m = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) m = 4'h1;
            set_keys(m);
            run($urandom_range(1, 45));
            set_keys(4'h0);
            run($urandom_range(1, 14));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
